// File: rtl/imem_loader.sv
// imem_loader: byte-stream program loader for the instruction memory.
// Parses a 4-byte big-endian word count, packs the following bytes into
// big-endian 32-bit words, writes them to imem and checks a trailing
// mod-256 checksum. The processor is held in reset until a load succeeds.
module imem_loader #(
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          DEPTH_WORDS = 64,
   parameter int          ADDR_W      = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   input  logic [7:0]        in_data,
   output logic              in_ready,
   input  logic              restart,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              done,
   output logic [1:0]        err_code,
   output logic              cpu_reset_n
);

   localparam int CNT_W = $clog2(DEPTH_WORDS + 1);

   typedef enum logic [2:0] {
      S_HDR  = 3'd0,
      S_DATA = 3'd1,
      S_CSUM = 3'd2,
      S_DONE = 3'd3,
      S_ERR  = 3'd4
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [1:0]        r_byte_cnt;
   logic [CNT_W-1:0]  r_word_cnt;
   logic [CNT_W-1:0]  r_nwords;
   logic [23:0]       r_shift;
   logic [7:0]        r_csum;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [31:0]       r_mem_wdata;
   logic [1:0]        r_err_code;
   logic [1:0]        w_err_nxt;

   logic              w_accept;
   logic              w_last_byte;
   logic              w_last_word;
   logic              w_restart;
   logic [31:0]       w_word;
   logic [7:0]        w_csum_sum;

   // The three previously received bytes plus the current one form a
   // big-endian word; used both for the header count and for data words.
   assign w_accept    = in_valid & in_ready;
   assign w_last_byte = (r_byte_cnt == 2'd3);
   assign w_last_word = ((r_word_cnt + CNT_W'(1)) == r_nwords);
   assign w_word      = {r_shift, in_data};
   assign w_csum_sum  = r_csum + in_data;
   assign w_restart   = restart & ((r_state == S_DONE) | (r_state == S_ERR));

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign err_code  = r_err_code;

   // State register and loader datapath.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= S_HDR;
         r_byte_cnt  <= '0;
         r_word_cnt  <= '0;
         r_nwords    <= '0;
         r_shift     <= '0;
         r_csum      <= '0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_err_code  <= 2'b00;
      end else begin
         r_state    <= w_state_nxt;
         r_err_code <= w_err_nxt;
         r_mem_we   <= 1'b0;
         if (w_restart) begin
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_nwords   <= '0;
            r_shift    <= '0;
            r_csum     <= '0;
         end else if (w_accept) begin
            r_csum     <= w_csum_sum;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            r_shift    <= {r_shift[15:0], in_data};
            // Count is range-checked before DATA is entered, so the
            // truncated copy is exact whenever it is used.
            if (w_last_byte && (r_state == S_HDR)) begin
               r_nwords <= w_word[CNT_W-1:0];
            end
            if (w_last_byte && (r_state == S_DATA)) begin
               r_mem_we    <= 1'b1;
               r_mem_addr  <= ADDR_W'(BASE_ADDR) + (ADDR_W'(r_word_cnt) << 2);
               r_mem_wdata <= w_word;
               r_word_cnt  <= r_word_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Next-state, error code and state-decoded handshake/status outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_err_nxt   = r_err_code;
      in_ready    = 1'b0;
      done        = 1'b0;
      cpu_reset_n = 1'b0;
      case (r_state)
         S_HDR: begin
            in_ready = 1'b1;
            if (w_accept && w_last_byte) begin
               if (w_word > 32'(DEPTH_WORDS)) begin
                  w_state_nxt = S_ERR;
                  w_err_nxt   = 2'b01;
               end else if (w_word == 32'd0) begin
                  w_state_nxt = S_CSUM;
               end else begin
                  w_state_nxt = S_DATA;
               end
            end
         end
         S_DATA: begin
            in_ready = 1'b1;
            if (w_accept && w_last_byte && w_last_word) begin
               w_state_nxt = S_CSUM;
            end
         end
         S_CSUM: begin
            in_ready = 1'b1;
            if (w_accept) begin
               if (w_csum_sum == 8'd0) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_ERR;
                  w_err_nxt   = 2'b10;
               end
            end
         end
         S_DONE: begin
            done        = 1'b1;
            cpu_reset_n = 1'b1;
            if (restart) begin
               w_state_nxt = S_HDR;
               w_err_nxt   = 2'b00;
            end
         end
         S_ERR: begin
            if (restart) begin
               w_state_nxt = S_HDR;
               w_err_nxt   = 2'b00;
            end
         end
         default: begin
            w_state_nxt = S_HDR;
         end
      endcase
   end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: directed byte streams push expected
// imem writes into a queue; a monitor pops and compares on every mem_we.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        restart;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        done;
   logic [1:0]  err_code;
   logic        cpu_reset_n;

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t exp_q[$];

   logic [7:0] prog [13] = '{8'h00, 8'h00, 8'h00, 8'h02,
                             8'h20, 8'h10, 8'h00, 8'h04,
                             8'h20, 8'h08, 8'h00, 8'h01,
                             8'hA1};

   imem_loader #(
      .BASE_ADDR  (32'h0),
      .DEPTH_WORDS(64),
      .ADDR_W     (32)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .restart    (restart),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .done       (done),
      .err_code   (err_code),
      .cpu_reset_n(cpu_reset_n)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every write strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_mem_we_addr", mem_addr, 32'hFFFF_FFFF);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            check("mem_addr", mem_addr, w.addr);
            check("mem_wdata", mem_wdata, w.data);
         end
      end
   end

   task automatic send_byte(input logic [7:0] b);
      int t;
      t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (in_ready !== 1'b1 && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (t >= 20) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
   endtask

   task automatic idle();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Send the first nsend bytes of the two-word program, optionally with a
   // one-cycle in_valid gap after each byte.
   task automatic send_prog(input logic [7:0] csum_b, input bit gaps, input int nsend);
      for (int i = 0; i < nsend; i++) begin
         send_byte((i == 12) ? csum_b : prog[i]);
         if (i == 7)  exp_q.push_back({32'h0000_0000, 32'h2010_0004});
         if (i == 11) exp_q.push_back({32'h0000_0004, 32'h2008_0001});
         if (gaps) idle();
      end
      idle();
   endtask

   task automatic do_restart();
      @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
   endtask

   task automatic check_done_ok(input string tag);
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_cpu_reset_n"}, cpu_reset_n, 1'b1);
      check({tag, "_err_code"}, err_code, 2'b00);
      check({tag, "_in_ready"}, in_ready, 1'b0);
      check({tag, "_pending_writes"}, exp_q.size(), 0);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_in_ready"}, in_ready, 1'b1);
      check({tag, "_mem_we"}, mem_we, 1'b0);
      check({tag, "_mem_addr"}, mem_addr, 32'h0);
      check({tag, "_mem_wdata"}, mem_wdata, 32'h0);
      check({tag, "_done"}, done, 1'b0);
      check({tag, "_err_code"}, err_code, 2'b00);
      check({tag, "_cpu_reset_n"}, cpu_reset_n, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      restart  = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_vals("reset");
      reset_n = 1'b1;

      // Test 1: two-word load, good checksum.
      send_prog(8'hA1, 1'b0, 13);
      check_done_ok("t1");
      do_restart();

      // Test 2: bad checksum; writes still happen.
      send_prog(8'hA2, 1'b0, 13);
      check("t2_err_code", err_code, 2'b10);
      check("t2_done", done, 1'b0);
      check("t2_cpu_reset_n", cpu_reset_n, 1'b0);
      check("t2_in_ready", in_ready, 1'b0);
      check("t2_pending_writes", exp_q.size(), 0);
      do_restart();
      check("t2_restart_err_code", err_code, 2'b00);
      check("t2_restart_in_ready", in_ready, 1'b1);

      // Test 3: header count 65 overflows; further bytes are refused.
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h41);
      idle();
      check("t3_err_code", err_code, 2'b01);
      check("t3_in_ready", in_ready, 1'b0);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 8'h11 * i[7:0];
      end
      idle();
      check("t3_err_hold", err_code, 2'b01);
      check("t3_in_ready_hold", in_ready, 1'b0);
      check("t3_cpu_reset_n", cpu_reset_n, 1'b0);
      do_restart();

      // Test 4: test 1 with in_valid gaps.
      send_prog(8'hA1, 1'b1, 13);
      check_done_ok("t4");
      do_restart();

      // Test 5: reset after 6 bytes, then a full reload.
      send_prog(8'hA1, 1'b0, 6);
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check_reset_vals("t5_reset");
      reset_n = 1'b1;
      send_prog(8'hA1, 1'b0, 13);
      check_done_ok("t5");
      do_restart();

      // Test 6: empty program, zero checksum, then restart.
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      send_byte(8'h00);
      idle();
      check_done_ok("t6");
      do_restart();
      check("t6_restart_done", done, 1'b0);
      check("t6_restart_cpu_reset_n", cpu_reset_n, 1'b0);
      check("t6_restart_in_ready", in_ready, 1'b1);

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
